// File: rtl/quokka_panel_pkg.sv
// Shared front-panel definitions: scanner state encoding, default chain
// geometry and the bit positions of the named panel switches.
package quokka_panel_pkg;

  // Scanner sequence: gap, parallel load, serial shift, commit.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } scan_state_e;

  // Default chain geometry: three 8-bit PISO registers.
  localparam int PANEL_NUM_BITS       = 24;
  localparam int PANEL_CLK_DIV        = 4;
  localparam int PANEL_SCAN_GAP       = 64;
  localparam int PANEL_DEBOUNCE_SCANS = 4;

  // Bit positions of the named switches in the committed switch word.
  localparam int SW_RUN          = 23;
  localparam int SW_HALT         = 22;
  localparam int SW_STEP         = 21;
  localparam int SW_EXAMINE      = 20;
  localparam int SW_EXAMINE_NEXT = 19;
  localparam int SW_DEPOSIT      = 18;
  localparam int SW_DEPOSIT_NEXT = 17;
  localparam int SW_LOAD_ADDR    = 16;
  localparam int SW_DATA_MSB     = 15;
  localparam int SW_DATA_LSB     = 0;

  // One-hot mask for a named switch, for decoding switches/switchPressed.
  function automatic logic [PANEL_NUM_BITS-1:0] panel_sw_mask(input int idx);
    return PANEL_NUM_BITS'(1) << idx;
  endfunction

endpackage

// File: rtl/panel_sclk_tick.sv
// Phase timer for the panel scanner: counts CLK_DIV clk cycles and flags the
// last cycle of each phase. The scanner holds it cleared while idle so every
// load pulse starts on a fresh phase.
module panel_sclk_tick
  import quokka_panel_pkg::*;
#(
  parameter int CLK_DIV = PANEL_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic phase_end_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign phase_end_o = (cnt_q == CNT_LAST);

  // Phase counter: wraps at the end of each phase, cleared on restart.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart_i || phase_end_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/panel_switch_scanner.sv
// Front-panel switch scanner for a chain of 74HC165-style PISO registers.
// Pulses sload_n, clocks the chain with sclk, assembles the serial stream
// (first bit out lands in the MSB) and publishes a committed switch word with
// a one-cycle valid strobe and 0->1 "pressed" bits.
// Optional feature: define PANEL_DEBOUNCE_EN to commit only after
// DEBOUNCE_SCANS identical consecutive scans.
module panel_switch_scanner
  import quokka_panel_pkg::*;
#(
  parameter int NUM_BITS = PANEL_NUM_BITS,
  parameter int CLK_DIV  = PANEL_CLK_DIV,
  parameter int SCAN_GAP = PANEL_SCAN_GAP
`ifdef PANEL_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_SCANS = PANEL_DEBOUNCE_SCANS
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scanEnable,
  input  logic                sdata_in,
  output logic                sclk,
  output logic                sload_n,
  output logic [NUM_BITS-1:0] switches,
  output logic                switchesValid,
  output logic [NUM_BITS-1:0] switchPressed
);

  localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam int BIT_W = $clog2(NUM_BITS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

  scan_state_e         state_q;
  logic [GAP_W-1:0]    gap_q;
  logic [BIT_W-1:0]    bit_q;
  logic                sclk_q;
  logic                sload_n_q;
  logic [NUM_BITS-1:0] shreg_q;
  logic                sync1_q, sync2_q;
  logic                phase_end;

  logic [NUM_BITS-1:0] switches_q, switches_d;
  logic [NUM_BITS-1:0] pressed_q, pressed_d;
  logic                valid_q;

`ifdef PANEL_DEBOUNCE_EN
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SCANS);

  logic [NUM_BITS-1:0] prev_raw_q, prev_raw_d;
  logic [MW-1:0]       match_q, match_d;
`endif

  panel_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .restart_i   (state_q == ST_IDLE),
    .phase_end_o (phase_end)
  );

  // Two-flop synchroniser for the asynchronous chain output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sdata_in;
      sync2_q <= sync1_q;
    end
  end

  // Scan sequencer: gap, load pulse, NUM_BITS low/high sclk slots, commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      sload_n_q <= 1'b1;
      // NOTE: the shift register is reset too, so an aborted scan never leaves X or stale bits behind.
      shreg_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (gap_q == GAP_LAST) begin
            if (scanEnable) begin
              state_q   <= ST_LOAD;
              sload_n_q <= 1'b0;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        ST_LOAD: begin
          if (phase_end) begin
            state_q   <= ST_SHIFT;
            sload_n_q <= 1'b1;
            bit_q     <= '0;
          end
        end
        ST_SHIFT: begin
          if (phase_end) begin
            if (!sclk_q) begin
              // Last low cycle: capture the bit before the rising edge shifts the chain.
              shreg_q <= {shreg_q[NUM_BITS-2:0], sync2_q};
              sclk_q  <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                state_q <= ST_COMMIT;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end
          end
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
          gap_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Commit decision: new switch word and its 0->1 edges for this scan.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
`ifdef PANEL_DEBOUNCE_EN
    prev_raw_d = shreg_q;
    if (shreg_q == prev_raw_q) begin
      match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
    end else begin
      match_d = MW'(1);
    end
    switches_d = switches_q;
    pressed_d  = '0;
    if ((match_d == MATCH_MAX) && (shreg_q != switches_q)) begin
      switches_d = shreg_q;
      pressed_d  = shreg_q & ~switches_q;
    end
`else
    switches_d = shreg_q;
    pressed_d  = shreg_q & ~switches_q;
`endif
  end

  // Registered outputs: update on the edge that leaves COMMIT, strobe for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      switches_q <= '0;
      pressed_q  <= '0;
      valid_q    <= 1'b0;
`ifdef PANEL_DEBOUNCE_EN
      prev_raw_q <= '0;
      match_q    <= '0;
`endif
    end else if (state_q == ST_COMMIT) begin
      switches_q <= switches_d;
      pressed_q  <= pressed_d;
      valid_q    <= 1'b1;
`ifdef PANEL_DEBOUNCE_EN
      prev_raw_q <= prev_raw_d;
      match_q    <= match_d;
`endif
    end else begin
      pressed_q <= '0;
      valid_q   <= 1'b0;
    end
  end

  assign sclk          = sclk_q;
  assign sload_n       = sload_n_q;
  assign switches      = switches_q;
  assign switchesValid = valid_q;
  assign switchPressed = pressed_q;

endmodule

// File: tb/tb_panel_switch_scanner.sv
// Bench for panel_switch_scanner: a behavioural three-register 74HC165 chain
// feeds the DUT; a scan-schedule model predicts every output on every cycle,
// and directed phases pin timing, data, edges, enable and reset behaviour.
// Build with PANEL_DEBOUNCE_EN defined to exercise the debounce variant.
module tb_panel_switch_scanner;

  localparam int NB       = 24;
  localparam int CD       = 2;
  localparam int GAP      = 4;
  localparam int SCAN_LEN = CD + 2 * CD * NB + 1;  // load start to valid cycle
  localparam int PERIOD   = SCAN_LEN + GAP;
`ifdef PANEL_DEBOUNCE_EN
  localparam int DEB = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scanEnable = 1'b1;
  logic          sdata_in;
  logic          sclk, sload_n, switchesValid;
  logic [NB-1:0] switches, switchPressed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  panel_switch_scanner #(
    .NUM_BITS (NB),
    .CLK_DIV  (CD),
    .SCAN_GAP (GAP)
`ifdef PANEL_DEBOUNCE_EN
    ,
    .DEBOUNCE_SCANS (DEB)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .scanEnable    (scanEnable),
    .sdata_in      (sdata_in),
    .sclk          (sclk),
    .sload_n       (sload_n),
    .switches      (switches),
    .switchesValid (switchesValid),
    .switchPressed (switchPressed)
  );

  // Behavioural 74HC165 chain: async parallel load while sload_n is low,
  // shift towards QH on each sclk rising edge; serial input tied low.
  logic [NB-1:0] preset;
  logic [NB-1:0] chain = '0;
  always @(posedge sclk or negedge sload_n) begin
    if (!sload_n) chain <= preset;
    else          chain <= {chain[NB-2:0], 1'b0};
  end
  assign sdata_in = chain[NB-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- scan-schedule model ----------------
  int            m_n, m_start, m_decision, rel;
  bit            m_active;
  logic [NB-1:0] m_latched, m_committed, m_next, exp_pressed;
  logic          exp_sclk, exp_load_n, exp_valid;
  logic [NB-1:0] hist[$];

  // Word the switches must hold after a scan that read raw.
  function automatic logic [NB-1:0] next_committed(input logic [NB-1:0] raw,
                                                   input logic [NB-1:0] cur);
`ifdef PANEL_DEBOUNCE_EN
    int run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == raw; i--) run++;
    return (run >= DEB) ? raw : cur;
`else
    if (cur == raw) return cur;
    return raw;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_n         = -1;
      m_active    = 1'b0;
      m_decision  = GAP - 1;
      m_committed = '0;
      hist.delete();
      check("rst_sclk",    32'(sclk),          32'd0);
      check("rst_sload_n", 32'(sload_n),       32'd1);
      check("rst_valid",   32'(switchesValid), 32'd0);
      check("rst_sw",      32'(switches),      32'd0);
      check("rst_pressed", 32'(switchPressed), 32'd0);
    end else begin
      m_n++;
      rel = m_active ? (m_n - m_start) : -1;
      if (rel == 0) m_latched = preset;
      exp_load_n  = !(rel >= 0 && rel < CD);
      exp_sclk    = (rel >= CD) && (rel < CD + 2 * CD * NB) && (((rel - CD) % (2 * CD)) >= CD);
      exp_valid   = (rel == SCAN_LEN);
      exp_pressed = '0;
      if (exp_valid) begin
        hist.push_back(m_latched);
        m_next      = next_committed(m_latched, m_committed);
        exp_pressed = m_next & ~m_committed;
        m_committed = m_next;
        m_active    = 1'b0;
        m_decision  = m_n + GAP - 1;
      end
      if (!m_active && m_n >= m_decision && scanEnable) begin
        m_active = 1'b1;
        m_start  = m_n + 1;
      end
      check("cyc_sclk",    32'(sclk),          32'(exp_sclk));
      check("cyc_sload_n", 32'(sload_n),       32'(exp_load_n));
      check("cyc_valid",   32'(switchesValid), 32'(exp_valid));
      check("cyc_sw",      32'(switches),      32'(m_committed));
      check("cyc_pressed", 32'(switchPressed), 32'(exp_pressed));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic drive_preset(input logic [NB-1:0] v);
    @(posedge clk);
    #1 preset = v;
  endtask

  task automatic wait_valid(input int budget, output logic [NB-1:0] sw,
                            output logic [NB-1:0] pr, output int waited);
    sw = '0;
    pr = '0;
    waited = 0;
    while (waited < budget) begin
      @(negedge clk);
      if (switchesValid) begin
        sw = switches;
        pr = switchPressed;
        return;
      end
      waited++;
    end
    check("valid_seen", 32'(switchesValid), 32'd1);
  endtask

  task automatic wait_load_start(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!sload_n) return;
    end
    check("load_seen", 32'(sload_n), 32'd0);
  endtask

  // Waits for sclk to have risen `rises` times since the current load.
  task automatic wait_rises(input int rises);
    int   cnt = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (sclk && !prev) cnt++;
      prev = sclk;
      if (cnt >= rises) return;
    end
    check("sclk_rises_reached", 32'(cnt), 32'(rises));
  endtask

  // Observes one full scan from load start to the next load start.
  task automatic measure_scan(output logic [NB-1:0] sw, output logic [NB-1:0] pr);
    int   lo = 0, rises = 0, bad_hi = 0, hi = 0, vc = 0, cyc;
    bit   load_done = 1'b0;
    logic prev = 1'b0;
    sw = '0;
    pr = '0;
    wait_load_start(2 * PERIOD);
    for (cyc = 0; cyc < 2 * PERIOD; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!sload_n && load_done) break;
      if (!sload_n) lo++;
      else load_done = 1'b1;
      if (sclk && !prev) rises++;
      if (sclk) hi++;
      else begin
        if (hi != 0 && hi != CD) bad_hi++;
        hi = 0;
      end
      prev = sclk;
      if (switchesValid) begin
        vc++;
        sw = switches;
        pr = switchPressed;
      end
    end
    check("load_low_cycles", 32'(lo),     32'd2);
    check("sclk_rises",      32'(rises),  32'd24);
    check("sclk_high_width", 32'(bad_hi), 32'd0);
    check("valid_pulses",    32'(vc),     32'd1);
    // 4 gap + 2 load + 96 shift + 1 commit
    check("scan_period",     32'(cyc),    32'd103);
  endtask

  // ---------------- directed sequence ----------------
  logic [NB-1:0] sw, pr;
  int            waited, n_hi, n_lo, n_val;
  logic [NB-1:0] seq_raw[5];
  logic [NB-1:0] seq_sw[5];
  logic [NB-1:0] seq_pr[5];

  initial begin
`ifdef PANEL_DEBOUNCE_EN
    preset = 24'h000000;
`else
    preset = 24'hA5C33C;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sclk",    32'(sclk),     32'd0);
    check("reset_sload_n", 32'(sload_n),  32'd1);
    check("reset_sw",      32'(switches), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Timing and first data scan.
    measure_scan(sw, pr);
`ifdef PANEL_DEBOUNCE_EN
    check("deb_first_sw", 32'(sw), 32'h000000);
    // Scan 2 already loading 0; then raw 1,0,1,1,1.
    wait_valid(2 * PERIOD, sw, pr, waited);
    check("deb_zero_sw", 32'(sw), 32'h000000);
    seq_raw = '{24'h000001, 24'h000000, 24'h000001, 24'h000001, 24'h000001};
    seq_sw  = '{24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000001};
    seq_pr  = '{24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000001};
    for (int i = 0; i < 5; i++) begin
      drive_preset(seq_raw[i]);
      wait_valid(2 * PERIOD, sw, pr, waited);
      check("deb_seq_sw", 32'(sw), 32'(seq_sw[i]));
      check("deb_seq_pr", 32'(pr), 32'(seq_pr[i]));
    end
`else
    check("data_sw",      32'(sw), 32'hA5C33C);
    check("data_pressed", 32'(pr), 32'hA5C33C);
    // Scan 2 rereads the same word: nothing newly pressed.
    wait_valid(2 * PERIOD, sw, pr, waited);
    check("repeat_sw",      32'(sw), 32'hA5C33C);
    check("repeat_pressed", 32'(pr), 32'h000000);
    seq_raw = '{24'h000081, 24'h000181, 24'h000080, 24'h000000, 24'h000000};
    seq_pr  = '{24'h000081, 24'h000100, 24'h000000, 24'h000000, 24'h000000};
    for (int i = 0; i < 3; i++) begin
      drive_preset(seq_raw[i]);
      wait_valid(2 * PERIOD, sw, pr, waited);
      check("edge_sw",      32'(sw), 32'(seq_raw[i]));
      check("edge_pressed", 32'(pr), 32'(seq_pr[i]));
    end
`endif

    // Enable dropped mid-shift: this scan still commits, then the FSM parks.
    drive_preset(24'h5A5A5A);
    wait_load_start(2 * PERIOD);
    wait_rises(10);
    @(posedge clk);
    #1 scanEnable = 1'b0;
    wait_valid(2 * PERIOD, sw, pr, waited);
`ifndef PANEL_DEBOUNCE_EN
    check("enable_last_sw", 32'(sw), 32'h5A5A5A);
`endif
    n_hi = 0;
    n_lo = 0;
    n_val = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (sclk) n_hi++;
      if (!sload_n) n_lo++;
      if (switchesValid) n_val++;
    end
    check("parked_sclk_high",  32'(n_hi),  32'd0);
    check("parked_load_low",   32'(n_lo),  32'd0);
    check("parked_valid",      32'(n_val), 32'd0);
    @(posedge clk);
    #1 scanEnable = 1'b1;
    wait_valid(2 * PERIOD, sw, pr, waited);

    // Reset in the middle of SHIFT while sclk is high.
    drive_preset(24'h00F00F);
    wait_load_start(2 * PERIOD);
    wait_rises(5);
    #2 rst = 1'b1;
    #1;
    check("midrst_sclk",    32'(sclk),          32'd0);
    check("midrst_sload_n", 32'(sload_n),       32'd1);
    check("midrst_sw",      32'(switches),      32'd0);
    check("midrst_valid",   32'(switchesValid), 32'd0);
    check("midrst_pressed", 32'(switchPressed), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_valid(2 * PERIOD, sw, pr, waited);
    // 4 gap + 99 to the valid cycle, no earlier pulse.
    check("restart_latency", 32'(waited), 32'd103);
`ifndef PANEL_DEBOUNCE_EN
    check("restart_sw",      32'(sw), 32'h00F00F);
    check("restart_pressed", 32'(pr), 32'h00F00F);
`endif

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
